// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake and BCD digit bus between a requester and bin_to_bcd_seq.
// The requester drives start/bin; the converter returns status and the four display digits.
interface bin_to_bcd_seq_if #(
    parameter int IN_WIDTH = 14
);
    logic                start;
    logic [IN_WIDTH-1:0] bin;
    logic                busy;
    logic                done;
    logic                ovf;
    logic [3:0]          bcd_3;
    logic [3:0]          bcd_2;
    logic [3:0]          bcd_1;
    logic [3:0]          bcd_0;

    modport master (
        output start, bin,
        input  busy, done, ovf, bcd_3, bcd_2, bcd_1, bcd_0
    );

    modport slave (
        input  start, bin,
        output busy, done, ovf, bcd_3, bcd_2, bcd_1, bcd_0
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Result registers hold between conversions; values above 9999 show as blank with ovf set.
module bin_to_bcd_seq #(
    parameter int IN_WIDTH      = 14,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    bin_to_bcd_seq_if.slave   bus
);

    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    state_t              state_q, state_d;
    logic [IN_WIDTH-1:0] bin_q,   bin_d;
    logic [19:0]         bcd_q,   bcd_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [15:0]         dig_q,   dig_d;
    logic                ovf_q,   ovf_d;
    logic                done_q,  done_d;

    logic [19:0]            adj;
    logic [20+IN_WIDTH-1:0] shifted;
    logic [15:0]            fin_dig;
    logic                   fin_ovf;

    // Add-3 correction is taken on the pre-shift value, then {bcd, bin} moves left once.
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj, bin_q} << 1;
    end

    always_comb begin
        fin_ovf = 1'b0;
        fin_dig = bcd_q[15:0];
        if (bcd_q[19:16] != 4'd0) begin
            fin_ovf = 1'b1;
            fin_dig = 16'hFFFF;
        end else if (BLANK_LEADING) begin
            // Units digit is never blanked so zero still shows a single 0.
            if (bcd_q[15:12] == 4'd0) begin
                fin_dig[15:12] = 4'hF;
                if (bcd_q[11:8] == 4'd0) begin
                    fin_dig[11:8] = 4'hF;
                    if (bcd_q[7:4] == 4'd0) begin
                        fin_dig[7:4] = 4'hF;
                    end
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    bin_d   = bus.bin;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(IN_WIDTH);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = shifted[IN_WIDTH +: 20];
                bin_d = shifted[IN_WIDTH-1:0];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                dig_d   = fin_dig;
                ovf_d   = fin_ovf;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            dig_q   <= 16'hFFFF;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = done_q;
    assign bus.ovf   = ovf_q;
    assign bus.bcd_3 = dig_q[15:12];
    assign bus.bcd_2 = dig_q[11:8];
    assign bus.bcd_1 = dig_q[7:4];
    assign bus.bcd_0 = dig_q[3:0];

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench: two converters (no blanking / blanking) driven in lockstep with identical stimulus.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [13:0] bin = '0;
    int          checks = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq_if #(.IN_WIDTH(14)) if0 ();
    bin_to_bcd_seq_if #(.IN_WIDTH(14)) if1 ();

    assign if0.start = start;
    assign if0.bin   = bin;
    assign if1.start = start;
    assign if1.bin   = bin;

    bin_to_bcd_seq #(.IN_WIDTH(14), .BLANK_LEADING(1'b0)) u_dut0 (
        .clk_i    (clk),
        .resetn_i (resetn),
        .bus      (if0.slave)
    );

    bin_to_bcd_seq #(.IN_WIDTH(14), .BLANK_LEADING(1'b1)) u_dut1 (
        .clk_i    (clk),
        .resetn_i (resetn),
        .bus      (if1.slave)
    );

    // Issues one START pulse and returns cycles from the accepting edge to DONE and the busy cycle count.
    task automatic do_conv(input logic [13:0] v, output int lat, output int busy_cyc);
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        lat      = 0;
        busy_cyc = 0;
        while (!if0.done && lat < 40) begin
            if (if0.busy) busy_cyc++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetn = 1'b0;
        start  = 1'b1;
        bin    = 14'd1234;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({if1.busy, if1.done, if1.ovf} !== 3'b000) begin
            fails++;
            $display("FAIL reset_status: busy/done/ovf=%b expected 000", {if1.busy, if1.done, if1.ovf});
        end
        checks++;
        if ({if0.bcd_3, if0.bcd_2, if0.bcd_1, if0.bcd_0} !== 16'hFFFF) begin
            fails++;
            $display("FAIL reset_digits: got %h expected ffff", {if0.bcd_3, if0.bcd_2, if0.bcd_1, if0.bcd_0});
        end
        resetn = 1'b1;
        start  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({if0.busy, if0.done} !== 2'b00) begin
            fails++;
            $display("FAIL reset_no_start: busy/done=%b expected 00", {if0.busy, if0.done});
        end
    endtask

    task automatic test_basic();
        int lat, busy_cyc;
        do_conv(14'd1234, lat, busy_cyc);
        checks++;
        if (lat !== 15) begin
            fails++;
            $display("FAIL basic_latency: got %0d expected 15", lat);
        end
        checks++;
        if (busy_cyc !== 15) begin
            fails++;
            $display("FAIL basic_busy_cycles: got %0d expected 15", busy_cyc);
        end
        checks++;
        if ({if0.ovf, if0.bcd_3, if0.bcd_2, if0.bcd_1, if0.bcd_0} !== {1'b0, 16'h1234}) begin
            fails++;
            $display("FAIL basic_digits: ovf=%b bcd=%h expected ovf=0 bcd=1234",
                     if0.ovf, {if0.bcd_3, if0.bcd_2, if0.bcd_1, if0.bcd_0});
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (if0.done !== 1'b0) begin
            fails++;
            $display("FAIL basic_done_pulse: done=%b one cycle later, expected 0", if0.done);
        end
    endtask

    task automatic test_blanking();
        logic [13:0] v[4]    = '{14'd0, 14'd7, 14'd1005, 14'd9999};
        logic [15:0] exp1[4] = '{16'hFFF0, 16'hFFF7, 16'h1005, 16'h9999};
        logic [15:0] exp0[4] = '{16'h0000, 16'h0007, 16'h1005, 16'h9999};
        int lat, busy_cyc;
        for (int i = 0; i < 4; i++) begin
            do_conv(v[i], lat, busy_cyc);
            checks++;
            if ({if1.bcd_3, if1.bcd_2, if1.bcd_1, if1.bcd_0} !== exp1[i]) begin
                fails++;
                $display("FAIL blank_on_%0d: got %h expected %h", v[i],
                         {if1.bcd_3, if1.bcd_2, if1.bcd_1, if1.bcd_0}, exp1[i]);
            end
            checks++;
            if ({if0.bcd_3, if0.bcd_2, if0.bcd_1, if0.bcd_0} !== exp0[i]) begin
                fails++;
                $display("FAIL blank_off_%0d: got %h expected %h", v[i],
                         {if0.bcd_3, if0.bcd_2, if0.bcd_1, if0.bcd_0}, exp0[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [13:0] v[3]   = '{14'd10000, 14'd16383, 14'd42};
        logic [16:0] exp[3] = '{{1'b1, 16'hFFFF}, {1'b1, 16'hFFFF}, {1'b0, 16'hFF42}};
        int lat, busy_cyc;
        for (int i = 0; i < 3; i++) begin
            do_conv(v[i], lat, busy_cyc);
            checks++;
            if ({if1.ovf, if1.bcd_3, if1.bcd_2, if1.bcd_1, if1.bcd_0} !== exp[i]) begin
                fails++;
                $display("FAIL overflow_%0d: ovf/bcd=%h expected %h", v[i],
                         {if1.ovf, if1.bcd_3, if1.bcd_2, if1.bcd_1, if1.bcd_0}, exp[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int t;
        @(negedge clk);
        bin   = 14'd567;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        t     = 0;
        repeat (4) begin
            @(posedge clk);
            t++;
            @(negedge clk);
        end
        bin   = 14'd89;
        start = 1'b1;
        @(posedge clk);
        t++;
        @(negedge clk);
        start = 1'b0;
        bin   = 14'd1234;
        while (!if1.done && t < 40) begin
            @(posedge clk);
            t++;
            @(negedge clk);
        end
        checks++;
        if (t !== 15) begin
            fails++;
            $display("FAIL ignore_latency: got %0d expected 15", t);
        end
        checks++;
        if ({if1.bcd_3, if1.bcd_2, if1.bcd_1, if1.bcd_0} !== 16'hF567) begin
            fails++;
            $display("FAIL ignore_digits: got %h expected f567", {if1.bcd_3, if1.bcd_2, if1.bcd_1, if1.bcd_0});
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (if1.busy !== 1'b0) begin
            fails++;
            $display("FAIL ignore_no_queue: busy=%b expected 0", if1.busy);
        end
    endtask

    task automatic test_back_to_back();
        int d[$];
        @(negedge clk);
        bin   = 14'd250;
        start = 1'b1;
        @(posedge clk);
        for (int t = 1; t <= 40; t++) begin
            @(posedge clk);
            @(negedge clk);
            if (if1.done) d.push_back(t);
        end
        start = 1'b0;
        checks++;
        if (d.size() !== 2) begin
            fails++;
            $display("FAIL b2b_count: got %0d done pulses expected 2", d.size());
        end
        checks++;
        if (d.size() < 2 || d[0] !== 15 || d[1] !== 31) begin
            fails++;
            $display("FAIL b2b_timing: first done at %0d, second at %0d, expected 15 and 31",
                     (d.size() > 0) ? d[0] : -1, (d.size() > 1) ? d[1] : -1);
        end
        checks++;
        if ({if1.bcd_3, if1.bcd_2, if1.bcd_1, if1.bcd_0} !== 16'hF250) begin
            fails++;
            $display("FAIL b2b_digits: got %h expected f250", {if1.bcd_3, if1.bcd_2, if1.bcd_1, if1.bcd_0});
        end
        repeat (20) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        int lat, busy_cyc, dones;
        @(negedge clk);
        bin   = 14'd5678;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        checks++;
        if ({if1.busy, if1.done, if1.ovf} !== 3'b000) begin
            fails++;
            $display("FAIL midreset_status: busy/done/ovf=%b expected 000", {if1.busy, if1.done, if1.ovf});
        end
        checks++;
        if ({if1.bcd_3, if1.bcd_2, if1.bcd_1, if1.bcd_0} !== 16'hFFFF) begin
            fails++;
            $display("FAIL midreset_digits: got %h expected ffff", {if1.bcd_3, if1.bcd_2, if1.bcd_1, if1.bcd_0});
        end
        dones = 0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (if1.done) dones++;
        end
        checks++;
        if (dones !== 0) begin
            fails++;
            $display("FAIL midreset_no_done: got %0d done pulses expected 0", dones);
        end
        do_conv(14'd321, lat, busy_cyc);
        checks++;
        if ({if1.bcd_3, if1.bcd_2, if1.bcd_1, if1.bcd_0} !== 16'hF321 || lat !== 15) begin
            fails++;
            $display("FAIL midreset_next: got %h after %0d cycles expected f321 after 15",
                     {if1.bcd_3, if1.bcd_2, if1.bcd_1, if1.bcd_0}, lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_blanking();
        test_overflow();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
- Produces the four BCD digit buses that feed the 4-digit 7-segment display decoder.
- Accepts a binary value on a START/BUSY/DONE handshake and converts one bit per clock.
- Presents all four digits simultaneously on completion, with overflow indication and optional leading-zero blanking.

Parameters:
- IN_WIDTH, 14, width of the binary input. Legal range 4..16. The internal BCD shift register is always 5 digits (20 bits).
- BLANK_LEADING, 1, when 1 leading-zero digits BCD_3..BCD_1 are output as 4'hF, the blank code. When 0, zeros are shown.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RESETN  input  1  synchronous, active-low reset, sampled on the CLK rising edge.
- START  input  1  conversion request; sampled only in IDLE.
- BIN  input  IN_WIDTH  unsigned binary value; latched on the accepted START edge.
- BUSY  output  1  high while a conversion is in progress.
- DONE  output  1  one-cycle pulse when new digits are valid.
- OVF  output  1  registered; 1 when the last latched value exceeded 9999.
- BCD_3  output  4  thousands digit.
- BCD_2  output  4  hundreds digit.
- BCD_1  output  4  tens digit.
- BCD_0  output  4  units digit.

Behaviour:
- Reset (RESETN=0 at a rising edge):
  - State goes to IDLE; BUSY=0, DONE=0, OVF=0.
  - BCD_3..BCD_0 = 4'hF (display blank); shift registers are cleared.
  - Reset mid-conversion aborts it: no DONE, and outputs take the reset values.
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - START=1 at an edge (edge k) → latch BIN into the binary shift register, clear the 20-bit BCD register, load bit counter = IN_WIDTH, go to SHIFT.
  - START=0 → stay in IDLE; outputs hold.
- SHIFT, one bit per edge:
  - For each BCD nibble ≥5, add 3.
  - Then shift {bcd, bin} left by 1 and decrement the counter.
  - The add-3 and shift happen in the same cycle: corrections are computed on the pre-shift value.
  - After IN_WIDTH shifts (edge k+IN_WIDTH) go to FINISH.
- FINISH (edge k+IN_WIDTH+1):
  - Write outputs, pulse DONE=1 for exactly one cycle, go to IDLE.
- BUSY is 1 in SHIFT and FINISH, i.e. from after edge k through edge k+IN_WIDTH+1 exclusive.
- Latency: DONE is high in the cycle following edge k+IN_WIDTH+1 (15 cycles after the START edge for IN_WIDTH=14).
  - Back-to-back: a START held high is next accepted at the edge where DONE is high, giving a minimum period of IN_WIDTH+2 cycles.
- START while BUSY=1 is ignored: no queueing, and the latched BIN is unchanged.
- BIN changes after acceptance have no effect on the current conversion.
- Output rules at FINISH:
  - If ten-thousands digit ≠ 0 (value > 9999): OVF=1, all four BCD outputs = 4'hF.
  - Else OVF=0, and BCD_3..BCD_0 take the converted digits, each 0..9.
- Leading-zero blanking (BLANK_LEADING=1, OVF=0):
  - Scan from BCD_3 downward; each leading zero digit becomes 4'hF.
  - Scanning stops at the first nonzero digit.
  - BCD_0 is never blanked, so value 0 shows a single "0".
  - Interior zeros are shown (e.g. 1005 → 1,0,0,5).
- Outputs BCD_x and OVF change only at the FINISH edge or on reset; they hold between conversions.
- Simultaneous RESETN=0 and START=1: reset wins; START is discarded.
- No combinational path from any input to any output.

Test Plan:
- Reset: RESETN=0 for 2 cycles with START=1 → BUSY=0, DONE=0, OVF=0, BCD_3..0=F,F,F,F; no conversion starts after release until START is seen in IDLE.
- Basic, BLANK_LEADING=0, IN_WIDTH=14: BIN=1234, one-cycle START → BUSY high 15 cycles, DONE single pulse 15 cycles after the START edge, BCD=1,2,3,4, OVF=0.
- Blanking, BLANK_LEADING=1: BIN=0 → F,F,F,0. BIN=7 → F,F,F,7. BIN=1005 → 1,0,0,5. BIN=9999 → 9,9,9,9.
- Overflow: BIN=10000 → OVF=1, BCD=F,F,F,F. Then BIN=16383 → OVF=1. Then BIN=42 → OVF=0, BCD=F,F,4,2.
- Handshake: START pulsed again mid-conversion with a different BIN → ignored, result matches the first BIN. START held high continuously → conversions every 16 cycles.
- Reset mid-operation: RESETN=0 at cycle 6 of a conversion of BIN=5678 → no DONE, outputs return to F,F,F,F, BUSY=0. The next START with BIN=321 gives F,3,2,1 (BLANK_LEADING=1).
